// File: rtl/timersoc_gpio_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : timersoc_gpio_arbiter
//  Description : Round-robin arbiter and sequencer that shares the single
//                Avalon-MM GPIO PIO slave among NUM_REQ requesters. It grants
//                one request, drives the slave for one cycle, captures the
//                slave's registered readdata (1-cycle latency) and returns a
//                one-cycle ack to the winner.
//  Ports       : clk, reset_n          - clock, async active-low reset
//                req/req_write         - per-requester request and direction
//                req_addr/req_wdata    - packed per-requester address/data
//                ack                   - one-cycle completion pulse
//                rdata                 - read data, valid while ack pulses
//                busy                  - high whenever a transaction runs
//                avm_*                 - Avalon-MM master side to the slave
//  Revision    : 1.0 - initial release
// ============================================================================
module timersoc_gpio_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic [ADDR_W-1:0]         avm_address,
    output logic                      avm_chipselect,
    output logic                      avm_write_n,
    output logic [DATA_W-1:0]         avm_writedata,
    input  logic [DATA_W-1:0]         avm_readdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     last_q;
    logic [IDX_W-1:0]     g_q;
    logic                 wr_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic [DATA_W-1:0]    rdata_q;
    logic                 busy_q;
    logic [ADDR_W-1:0]    avm_address_q;
    logic                 avm_chipselect_q;
    logic                 avm_write_n_q;
    logic [DATA_W-1:0]    avm_writedata_q;

    logic                 hi_found_d;
    logic                 lo_found_d;
    logic [IDX_W-1:0]     hi_idx_d;
    logic [IDX_W-1:0]     lo_idx_d;
    logic                 grant_valid_d;
    logic [IDX_W-1:0]     grant_d;
    logic                 sel_write_d;
    logic [ADDR_W-1:0]    sel_addr_d;
    logic [DATA_W-1:0]    sel_wdata_d;

    // Round-robin pick: requesters above last_q take precedence over those at
    // or below it; within each group the lowest index wins. Scanning downward
    // lets the final assignment in each group be its lowest set bit.
    always_comb begin
        hi_found_d = 1'b0;
        lo_found_d = 1'b0;
        hi_idx_d   = '0;
        lo_idx_d   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (IDX_W'(i) > last_q) begin
                    hi_found_d = 1'b1;
                    hi_idx_d   = IDX_W'(i);
                end else begin
                    lo_found_d = 1'b1;
                    lo_idx_d   = IDX_W'(i);
                end
            end
        end
        grant_valid_d = hi_found_d | lo_found_d;
        grant_d       = hi_found_d ? hi_idx_d : lo_idx_d;

        sel_write_d = 1'b0;
        sel_addr_d  = '0;
        sel_wdata_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == grant_d) begin
                sel_write_d = req_write[i];
                sel_addr_d  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata_d = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // All outputs are registered, so each state's bus values are loaded on
    // the transition into that state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            last_q           <= IDX_W'(NUM_REQ - 1);
            g_q              <= '0;
            wr_q             <= 1'b0;
            ack_q            <= '0;
            rdata_q          <= '0;
            busy_q           <= 1'b0;
            avm_address_q    <= '0;
            avm_chipselect_q <= 1'b0;
            avm_write_n_q    <= 1'b1;
            avm_writedata_q  <= '0;
        end else begin
            ack_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid_d) begin
                        // Fields are latched here; later requester changes
                        // cannot disturb the transaction.
                        g_q              <= grant_d;
                        last_q           <= grant_d;
                        wr_q             <= sel_write_d;
                        avm_address_q    <= sel_addr_d;
                        avm_writedata_q  <= sel_wdata_d;
                        avm_chipselect_q <= 1'b1;
                        avm_write_n_q    <= ~sel_write_d;
                        busy_q           <= 1'b1;
                        state_q          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    avm_chipselect_q <= 1'b0;
                    avm_write_n_q    <= 1'b1;
                    state_q          <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Slave readdata is valid this cycle (registered on the
                    // edge that ended ISSUE).
                    if (!wr_q) begin
                        rdata_q <= avm_readdata;
                    end
                    for (int i = 0; i < NUM_REQ; i++) begin
                        ack_q[i] <= (IDX_W'(i) == g_q);
                    end
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack            = ack_q;
    assign rdata          = rdata_q;
    assign busy           = busy_q;
    assign avm_address    = avm_address_q;
    assign avm_chipselect = avm_chipselect_q;
    assign avm_write_n    = avm_write_n_q;
    assign avm_writedata  = avm_writedata_q;

endmodule
`default_nettype wire
